// File: rtl/sram_rw_port_ctrl_pkg.sv
// sram_rw_port_ctrl_pkg: shared FSM state and grant encodings for the SRAM port controller
package sram_rw_port_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Doubles as the bit position of each requester in the one-hot grant vector
    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } gnt_t;

endpackage

// File: rtl/sram_rw_port_ctrl_arb.sv
// rr_arb2: two-way round-robin arbiter, the requester not granted last wins a conflict
module rr_arb2
    import sram_rw_port_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    gnt_t last_q, last_d;

    // One-hot grant; a lone request is granted outright, a conflict goes to the other side of last_q
    always_comb begin
        gnt    = '0;
        last_d = last_q;
        if (en) begin
            gnt[GNT_RD] = req[GNT_RD] && !(req[GNT_WR] && last_q == GNT_RD);
            gnt[GNT_WR] = req[GNT_WR] && !(req[GNT_RD] && last_q == GNT_WR);
        end
        if (gnt[GNT_RD])
            last_d = GNT_RD;
        else if (gnt[GNT_WR])
            last_d = GNT_WR;
    end

    // Last-grant register; resets to write so read wins the first conflict
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            last_q <= GNT_WR;
        else
            last_q <= last_d;
    end

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// sram_rw_port_ctrl: shares one SRAM RW port between an array clear sequencer, a reader and a writer
module sram_rw_port_ctrl
    import sram_rw_port_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 20,
    parameter int                DEPTH    = 1024,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clr_req,
    output logic              init_done,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic              sram_wmask,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              init_done_q, init_done_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [1:0]        gnt;
    logic              arb_en;

    // Requests are only served in RUN, and not in the cycle a clear is taken
    assign arb_en = (state_q == ST_RUN) && !clr_req;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (arb_en),
        .req     ({wr_valid, rd_valid}),
        .gnt     (gnt)
    );

    assign rd_ready   = gnt[GNT_RD];
    assign wr_ready   = gnt[GNT_WR];
    assign sram_wmask = sram_wmode;
    assign init_done  = init_done_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = sram_rdata;

    // Next state and SRAM port mux: clear sweep in INIT, granted request in RUN
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = rd_addr;
        sram_wdata = wr_data;
        if (state_q == ST_INIT) begin
            sram_en    = reset_n;
            sram_wmode = 1'b1;
            sram_addr  = clr_cnt_q;
            sram_wdata = INIT_VAL;
            clr_cnt_d  = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
                state_d   = ST_RUN;
                clr_cnt_d = '0;
            end
        end else if (clr_req) begin
            state_d = ST_INIT;
        end else if (gnt[GNT_WR]) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = wr_addr;
        end else if (gnt[GNT_RD]) begin
            sram_en = 1'b1;
        end
        init_done_d = (state_d == ST_RUN);
        rsp_valid_d = gnt[GNT_RD];
    end

    // State, clear counter, init_done and response-valid registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// tb_sram_rw_port_ctrl: randomized self-checking bench with a behavioural model of the port controller
module tb_sram_rw_port_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 20;
    localparam int DEPTH = 1024;
    localparam logic [DW-1:0] IV = '0;

    logic          clock = 1'b0;
    logic          reset_n, clr_req, init_done;
    logic          rd_valid, rd_ready, rsp_valid, wr_valid, wr_ready;
    logic [AW-1:0] rd_addr, wr_addr, sram_addr;
    logic [DW-1:0] rsp_data, wr_data, sram_wdata, sram_rdata;
    logic          sram_en, sram_wmode, sram_wmask;

    int checks = 0;
    int errors = 0;

    sram_rw_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .INIT_VAL(IV)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clr_req    (clr_req),
        .init_done  (init_done),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] sram_mem [DEPTH];
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) sram_mem[sram_addr] <= sram_wdata;
            else            sram_rdata <= sram_mem[sram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    bit            m_run, m_rd_turn, m_pend;
    int            m_addr;
    logic [DW-1:0] m_rsp;
    logic [DW-1:0] ref_mem [DEPTH];
    logic          e_rg, e_wg;

    assign e_rg = reset_n && m_run && !clr_req && rd_valid && (!wr_valid || m_rd_turn);
    assign e_wg = reset_n && m_run && !clr_req && wr_valid && (!rd_valid || !m_rd_turn);

    always @(posedge clock or negedge reset_n) begin : model
        bit rg, wg;
        if (!reset_n) begin
            m_run = 0; m_addr = 0; m_rd_turn = 1; m_pend = 0;
        end else begin
            rg = e_rg;
            wg = e_wg;
            m_pend = rg;
            if (rg) m_rsp = ref_mem[rd_addr];
            if (wg) ref_mem[wr_addr] = wr_data;
            if (rg) m_rd_turn = 0;
            else if (wg) m_rd_turn = 1;
            if (!m_run) begin
                ref_mem[m_addr] = IV;
                m_addr++;
                if (m_addr == DEPTH) begin
                    m_run = 1;
                    m_addr = 0;
                end
            end else if (clr_req) begin
                m_run = 0;
            end
        end
    end

    always @(negedge clock) begin
        chk("init_done", 32'(init_done), 32'(reset_n && m_run));
        chk("rsp_valid", 32'(rsp_valid), 32'(reset_n && m_pend));
        if (reset_n && m_pend) chk("rsp_data", 32'(rsp_data), 32'(m_rsp));
        chk("rd_ready", 32'(rd_ready), 32'(e_rg));
        chk("wr_ready", 32'(wr_ready), 32'(e_wg));
        chk("sram_en", 32'(sram_en), 32'(reset_n && (!m_run || e_rg || e_wg)));
        if (reset_n && !m_run) begin
            chk("clr_wmode", 32'(sram_wmode), 32'(1));
            chk("clr_wmask", 32'(sram_wmask), 32'(1));
            chk("clr_addr", 32'(sram_addr), 32'(m_addr));
            chk("clr_wdata", 32'(sram_wdata), 32'(IV));
        end else if (e_rg) begin
            chk("rd_wmode", 32'(sram_wmode), 32'(0));
            chk("rd_addr", 32'(sram_addr), 32'(rd_addr));
        end else if (e_wg) begin
            chk("wr_wmode", 32'(sram_wmode), 32'(1));
            chk("wr_wmask", 32'(sram_wmask), 32'(1));
            chk("wr_addr", 32'(sram_addr), 32'(wr_addr));
            chk("wr_wdata", 32'(sram_wdata), 32'(wr_data));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 1100) begin
            step();
            n++;
        end
    endtask

    initial begin
        #1_500_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 0; clr_req = 0;
        rd_valid = 1; wr_valid = 1; rd_addr = 5; wr_addr = 7; wr_data = 20'h11111;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_en", 32'(sram_en), 32'(0));
        chk("reset_init_done", 32'(init_done), 32'(0));
        reset_n = 1;
        #1;
        chk("first_clr_addr", 32'(sram_addr), 32'(0));
        wait_init(n);
        chk("init_len", 32'(n), 32'(1024));

        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_rd", 32'(rd_ready), 32'(i % 2 == 0));
            chk("rr_wr", 32'(wr_ready), 32'(i % 2 == 1));
            step();
        end
        rd_valid = 0;
        wr_valid = 1; wr_addr = 10'h3A; wr_data = 20'hABCDE;
        step();
        wr_valid = 0; rd_valid = 1; rd_addr = 10'h3A;
        #1;
        chk("wr_rd_ready", 32'(rd_ready), 32'(1));
        step();
        rd_valid = 0;
        chk("wr_rd_valid", 32'(rsp_valid), 32'(1));
        chk("wr_rd_data", 32'(rsp_data), 32'(20'hABCDE));

        wr_valid = 1; wr_addr = 10'h10; wr_data = 20'h12345;
        step();
        wr_valid = 0; rd_valid = 1; rd_addr = 10'h10;
        step();
        clr_req = 1;
        #1;
        chk("clr_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("clr_rsp_data", 32'(rsp_data), 32'(20'h12345));
        chk("clr_rd_ready", 32'(rd_ready), 32'(0));
        step();
        clr_req = 0;
        wait_init(n);
        chk("reclr_len", 32'(n), 32'(1024));
        step();
        rd_valid = 0;
        chk("cleared_valid", 32'(rsp_valid), 32'(1));
        chk("cleared_data", 32'(rsp_data), 32'(0));

        for (int i = 0; i < 6000; i++) begin
            rd_valid = 1'($urandom_range(0, 1));
            wr_valid = 1'($urandom_range(0, 1));
            rd_addr  = AW'($urandom_range(0, DEPTH - 1));
            wr_addr  = ($urandom_range(0, 3) == 0) ? rd_addr : AW'($urandom_range(0, DEPTH - 1));
            wr_data  = DW'($urandom);
            clr_req  = ($urandom_range(0, 399) == 0);
            step();
        end
        clr_req = 0; rd_valid = 0; wr_valid = 0;
        wait_init(n);
        chk("settled_run", 32'(init_done), 32'(1));

        clr_req = 1;
        step();
        clr_req = 0; rd_valid = 1; wr_valid = 1;
        n = 0;
        while (sram_addr != 10'd500 && n < 2000) begin
            step();
            n++;
        end
        chk("reach_500", 32'(sram_addr), 32'(500));
        reset_n = 0;
        #1;
        chk("rst_en", 32'(sram_en), 32'(0));
        chk("rst_rd_ready", 32'(rd_ready), 32'(0));
        chk("rst_wr_ready", 32'(wr_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_init_done", 32'(init_done), 32'(0));
        step();
        reset_n = 1;
        #1;
        chk("restart_addr", 32'(sram_addr), 32'(0));
        chk("restart_en", 32'(sram_en), 32'(1));
        wait_init(n);
        chk("restart_len", 32'(n), 32'(1024));
        rd_valid = 0; wr_valid = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
